ysyx_22050133_dmem_responder: RTL and testbench

//  Memory-side responder for the core's load/store port: accepts one read or write request at a time,

---
 rtl/ysyx_22050133_dmem_responder_pkg.sv | 26 ++
 rtl/ysyx_22050133_dmem_responder_if.sv | 22 ++
 rtl/ysyx_22050133_dmem_array.sv | 20 ++
 rtl/ysyx_22050133_dmem_responder.sv | 60 ++++++
 tb/tb_ysyx_22050133_dmem_responder.sv | 134 +++++++++++++
 5 files changed

// File: rtl/ysyx_22050133_dmem_responder_pkg.sv
// ysyx_22050133_dmem_responder_pkg: shared state encodings, request record and byte-lane helpers
package ysyx_22050133_dmem_responder_pkg;
  localparam int XLEN = 64;
  localparam int NBYTE = XLEN / 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  typedef struct packed {
    logic             wen;
    logic             err;
    logic [2:0]       off;
    logic [NBYTE-1:0] mask;
    logic [XLEN-1:0]  data;
  } req_t;
  function automatic logic [NBYTE-1:0] lane_mask(input logic [NBYTE-1:0] m, input logic [2:0] off);
    logic [2*NBYTE-1:0] t;
    t = {{NBYTE{1'b0}}, m} << off;
    return t[NBYTE-1:0];
  endfunction
  function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] d, input logic [2:0] off);
    return d << {off, 3'b000};
  endfunction
  function automatic logic [XLEN-1:0] align_rd(input logic [XLEN-1:0] w, input logic [2:0] off);
    return w >> {off, 3'b000};
  endfunction
endpackage

// File: rtl/ysyx_22050133_dmem_responder_if.sv
// ysyx_22050133_dmem_responder_if: request/response bus between the core load/store port and memory
interface ysyx_22050133_dmem_responder_if;
  import ysyx_22050133_dmem_responder_pkg::*;
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic             req_wen;
  logic [XLEN-1:0]  req_wdata;
  logic [NBYTE-1:0] req_wmask;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_rdata;
  logic             resp_err;
  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_22050133_dmem_array.sv
// ysyx_22050133_dmem_array: single-port word store with per-byte write enable and registered read
module ysyx_22050133_dmem_array #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 8; i++)
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/ysyx_22050133_dmem_responder.sv
// ysyx_22050133_dmem_responder: latency-configurable single-outstanding data memory responder
module ysyx_22050133_dmem_responder
  import ysyx_22050133_dmem_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int DEPTH = 4096,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  ysyx_22050133_dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  req_t            q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] rel;
  logic [XLEN-1:0] rd_word;
  logic            in_range;
  logic            last;
  logic            commit;
  logic            accept;
  assign rel = bus.req_addr - BASE_ADDR;
  assign in_range = bus.req_addr >= BASE_ADDR && (rel >> 3) < 64'(DEPTH);
  assign accept = state == S_IDLE && bus.req_valid;
  assign last = cnt == CW'(LATENCY - 1);
  // rst gates the commit because the array itself has no reset
  assign commit = state == S_WAIT && last && !rst;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state == S_IDLE ? (bus.req_valid ? S_WAIT : S_IDLE) :
               state == S_WAIT ? (last ? S_RESP : S_WAIT) :
               state == S_RESP ? (bus.resp_ready ? S_IDLE : S_RESP) : S_IDLE;
      cnt <= state == S_WAIT && !last ? cnt + 1'b1 : '0;
    end
  always_ff @(posedge clk)
    if (accept) begin
      q <= '{wen: bus.req_wen, err: !in_range, off: bus.req_addr[2:0],
             mask: lane_mask(bus.req_wmask, bus.req_addr[2:0]),
             data: lane_data(bus.req_wdata, bus.req_addr[2:0])};
      idx_q <= rel[AW+2:3];
    end
  ysyx_22050133_dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk  (clk),
    .en   (commit),
    .we   (q.wen && !q.err ? q.mask : '0),
    .addr (idx_q),
    .wdata(q.data),
    .rdata(rd_word)
  );
  assign bus.req_ready = state == S_IDLE;
  assign bus.resp_valid = state == S_RESP;
  assign bus.resp_err = bus.resp_valid && q.err;
  assign bus.resp_rdata = bus.resp_valid && !q.wen && !q.err ? align_rd(rd_word, q.off) : '0;
endmodule

// File: tb/tb_ysyx_22050133_dmem_responder.sv
// tb_ysyx_22050133_dmem_responder: directed checks of alignment, masking, range, stall and reset
module tb_ysyx_22050133_dmem_responder;
  logic clk;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  ysyx_22050133_dmem_responder_if bus ();
  ysyx_22050133_dmem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
    bus.req_addr = a;
    bus.req_wen = w;
    bus.req_wdata = d;
    bus.req_wmask = m;
    bus.req_valid = 1;
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    bus.req_addr = '1;
    bus.req_wen = ~w;
    bus.req_wdata = ~d;
    bus.req_wmask = ~m;
  endtask
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic txn(input string tag, input logic [63:0] a, input logic w, input logic [63:0] d,
                     input logic [7:0] m, input logic [63:0] exp_rd, input logic exp_err);
    int lat;
    send(a, w, d, m);
    wait_resp(lat);
    check({tag, ".lat"}, 64'(lat), 64'd2);
    check({tag, ".rd"}, bus.resp_rdata, exp_rd);
    check({tag, ".err"}, 64'(bus.resp_err), 64'(exp_err));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int lat;
    rst = 1;
    bus.req_valid = 0;
    bus.req_addr = 0;
    bus.req_wen = 0;
    bus.req_wdata = 0;
    bus.req_wmask = 0;
    bus.resp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", 64'(bus.req_ready), 64'd1);
    check("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst.rdata", bus.resp_rdata, 64'd0);
    check("rst.err", 64'(bus.resp_err), 64'd0);
    rst = 0;
    @(posedge clk);
    #1;
    txn("t1.wr", 64'h8000_0010, 1, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 0);
    txn("t1.rd", 64'h8000_0010, 0, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0);
    txn("t2.clr", 64'h8000_0010, 1, 64'd0, 8'hFF, 64'd0, 0);
    txn("t2.wr", 64'h8000_0013, 1, 64'hAB, 8'h01, 64'd0, 0);
    txn("t2.rd10", 64'h8000_0010, 0, 64'd0, 8'h00, 64'h0000_0000_AB00_0000, 0);
    txn("t2.rd13", 64'h8000_0013, 0, 64'd0, 8'h00, 64'h0000_0000_0000_00AB, 0);
    txn("t3.clr0", 64'h8000_0000, 1, 64'd0, 8'hFF, 64'd0, 0);
    txn("t3.init1", 64'h8000_0008, 1, 64'h0102_0304_0506_0708, 8'hFF, 64'd0, 0);
    txn("t3.wr", 64'h8000_0006, 1, 64'hCCDD, 8'h03, 64'd0, 0);
    txn("t3.rd0", 64'h8000_0000, 0, 64'd0, 8'h00, 64'hCCDD_0000_0000_0000, 0);
    txn("t3.rd1", 64'h8000_0008, 0, 64'd0, 8'h00, 64'h0102_0304_0506_0708, 0);
    txn("t3.wr0f", 64'h8000_0006, 1, 64'h1122_3344, 8'h0F, 64'd0, 0);
    txn("t3.rd0b", 64'h8000_0000, 0, 64'd0, 8'h00, 64'h3344_0000_0000_0000, 0);
    txn("t3.rd6", 64'h8000_0006, 0, 64'd0, 8'h00, 64'h0000_0000_0000_3344, 0);
    txn("t3.rd1b", 64'h8000_0008, 0, 64'd0, 8'h00, 64'h0102_0304_0506_0708, 0);
    txn("t4.rdlo", 64'h7FFF_FFF8, 0, 64'd0, 8'h00, 64'd0, 1);
    txn("t4.rdhi", 64'h8000_8000, 0, 64'd0, 8'h00, 64'd0, 1);
    txn("t4.wrhi", 64'h8000_8000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1);
    txn("t4.wrlo", 64'h7FFF_FFF8, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1);
    txn("t4.rd0", 64'h8000_0000, 0, 64'd0, 8'h00, 64'h3344_0000_0000_0000, 0);
    txn("t4.rd0ff8", 64'h8000_7FF8, 1, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 64'd0, 0);
    txn("t4.rdlast", 64'h8000_7FF8, 0, 64'd0, 8'h00, 64'hDEAD_BEEF_0BAD_F00D, 0);
    txn("m0.wr", 64'h8000_0010, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 0);
    txn("m0.rd", 64'h8000_0010, 0, 64'd0, 8'h00, 64'h0000_0000_AB00_0000, 0);
    bus.resp_ready = 0;
    send(64'h8000_0013, 0, 64'd0, 8'h00);
    wait_resp(lat);
    check("t5.lat", 64'(lat), 64'd2);
    bus.req_addr = 64'h8000_0010;
    bus.req_wen = 1;
    bus.req_wdata = 64'hEEEE_EEEE_EEEE_EEEE;
    bus.req_wmask = 8'hFF;
    bus.req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) bus.req_valid = 0;
      check($sformatf("t5.hold%0d.valid", i), 64'(bus.resp_valid), 64'd1);
      check($sformatf("t5.hold%0d.rd", i), bus.resp_rdata, 64'hAB);
      check($sformatf("t5.hold%0d.ready", i), 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1;
    @(posedge clk);
    #1;
    check("t5.rel.req_ready", 64'(bus.req_ready), 64'd1);
    check("t5.rel.resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    txn("t5.rd", 64'h8000_0010, 0, 64'd0, 8'h00, 64'h0000_0000_AB00_0000, 0);
    send(64'h8000_0010, 1, 64'h5555_5555_5555_5555, 8'hFF);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check("t6.req_ready", 64'(bus.req_ready), 64'd1);
    check("t6.resp_valid", 64'(bus.resp_valid), 64'd0);
    check("t6.rdata", bus.resp_rdata, 64'd0);
    check("t6.err", 64'(bus.resp_err), 64'd0);
    @(posedge clk);
    #1;
    check("t6.resp_valid2", 64'(bus.resp_valid), 64'd0);
    txn("t6.rd", 64'h8000_0010, 0, 64'd0, 8'h00, 64'h0000_0000_AB00_0000, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
